// File: rtl/s832_state_harness_if.sv
// Bus between the s832 state harness and its controller: the core's PPI/PPO pair plus
// the run, step and scan controls and status.
interface s832_state_harness_if #(
    parameter int STATE_W = 5
);
    logic [STATE_W-1:0] ppo;
    logic [STATE_W-1:0] ppi;
    logic               run;
    logic               step_req;
    logic               step_ack;
    logic               scan_en;
    logic               scan_in;
    logic               scan_out;
    logic               shift_done;
    logic               busy;
    logic               par_err;

    modport master (
        output ppo, run, step_req, scan_en, scan_in,
        input  ppi, step_ack, scan_out, shift_done, busy, par_err
    );

    modport slave (
        input  ppo, run, step_req, scan_en, scan_in,
        output ppi, step_ack, scan_out, shift_done, busy, par_err
    );
endinterface

// File: rtl/s832_state_harness.sv
// State flip-flops for the combinational s832 core: free-run, handshaked single-step and
// serial scan load/unload. Define STATE_PARITY_EN to add a sticky state-upset detector.
module s832_state_harness #(
    parameter int                 STATE_W     = 5,
    parameter logic [STATE_W-1:0] RESET_STATE = '0
) (
    input  logic                  CK,
    input  logic                  RST_N,
    s832_state_harness_if.slave   bus
);
    localparam int CNT_W = (STATE_W > 1) ? $clog2(STATE_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STATE_W - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] STEP  = 2'd2;
    localparam logic [1:0] SHIFT = 2'd3;

    logic [1:0]         fsm_q, fsm_d;
    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               seen_q, seen_d;
    logic               state_we;
    logic               step_go;

    // A step request is only honoured once per assertion of step_req.
    assign step_go = bus.step_req && !seen_q;

    always_comb begin
        fsm_d    = fsm_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        seen_d   = bus.step_req ? seen_q : 1'b0;
        state_we = 1'b0;
        if (bus.scan_en) begin
            fsm_d    = SHIFT;
            state_d  = {state_q[STATE_W-2:0], bus.scan_in};
            state_we = 1'b1;
            if (cnt_q == CNT_LAST) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (step_go) begin
                        fsm_d    = STEP;
                        state_d  = bus.ppo;
                        state_we = 1'b1;
                        seen_d   = 1'b1;
                    end else if (bus.run) begin
                        fsm_d    = RUN;
                        state_d  = bus.ppo;
                        state_we = 1'b1;
                    end
                end
                // A pending step ends free-run; it is serviced from IDLE.
                RUN: begin
                    if (step_go || !bus.run) begin
                        fsm_d = IDLE;
                    end else begin
                        state_d  = bus.ppo;
                        state_we = 1'b1;
                    end
                end
                STEP:  fsm_d = IDLE;
                SHIFT: begin
                    fsm_d = IDLE;
                    cnt_d = '0;
                end
                default: fsm_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            fsm_q   <= IDLE;
            state_q <= RESET_STATE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            seen_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            seen_q  <= seen_d;
        end
    end

    assign bus.ppi        = state_q;
    assign bus.scan_out   = state_q[STATE_W-1];
    assign bus.step_ack   = (fsm_q == STEP);
    assign bus.shift_done = done_q;
    assign bus.busy       = (fsm_q != IDLE);

`ifdef STATE_PARITY_EN
    logic parity_q;
    logic par_err_q;

    // Parity follows legitimate writes only, so a flop upset shows as a mismatch.
    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            parity_q  <= ^RESET_STATE;
            par_err_q <= 1'b0;
        end else begin
            if (state_we) begin
                parity_q <= ^state_d;
            end
            if ((^state_q) != parity_q) begin
                par_err_q <= 1'b1;
            end
        end
    end

    assign bus.par_err = par_err_q;
`else
    logic unused_we;
    assign unused_we   = state_we;
    assign bus.par_err = 1'b0;
`endif
endmodule

// File: tb/tb_s832_state_harness.sv
// Bench for s832_state_harness: directed scenarios plus randomized traffic against a
// behavioural model of the harness.
module tb_s832_state_harness;
    localparam int W = 5;

    logic CK = 1'b0;
    logic RST_N = 1'b0;
    int   checks = 0;
    int   passes = 0;

    s832_state_harness_if #(.STATE_W(W)) bus ();

    s832_state_harness #(.STATE_W(W), .RESET_STATE(5'b00000)) dut (
        .CK    (CK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CK = ~CK;

    // Behavioural model: mode flags plus state, shift count and req memory.
    logic [W-1:0] m_state;
    bit m_shifting, m_running, m_acking, m_done, m_seen;
    int m_cnt;

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic drive(input bit s, input bit sin, input bit r, input bit rn, input logic [W-1:0] p);
        bus.scan_en  = s;
        bus.scan_in  = sin;
        bus.step_req = r;
        bus.run      = rn;
        bus.ppo      = p;
    endtask

    task automatic model_reset();
        m_state = '0; m_shifting = 0; m_running = 0; m_acking = 0;
        m_done = 0; m_seen = 0; m_cnt = 0;
    endtask

    // One clock edge of the model, using the inputs currently on the bus.
    task automatic model_edge();
        bit seen_n;
        bit was_ack;
        seen_n  = bus.step_req ? m_seen : 1'b0;
        was_ack = m_acking;
        m_done   = 0;
        m_acking = 0;
        if (bus.scan_en) begin
            m_state    = {m_state[W-2:0], bus.scan_in};
            m_running  = 0;
            m_shifting = 1;
            if (m_cnt == W - 1) begin
                m_cnt  = 0;
                m_done = 1;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end else if (m_shifting) begin
            m_shifting = 0;
            m_cnt      = 0;
        end else if (was_ack) begin
            // back to idle
        end else if (m_running) begin
            if ((bus.step_req && !m_seen) || !bus.run) m_running = 0;
            else m_state = bus.ppo;
        end else if (bus.step_req && !m_seen) begin
            m_acking = 1;
            m_state  = bus.ppo;
            seen_n   = 1;
        end else if (bus.run) begin
            m_running = 1;
            m_state   = bus.ppo;
        end
        m_seen = seen_n;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        drive(0, 0, 0, 0, '0);
        repeat (2) tick();
        RST_N = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.ppi !== 5'b00000 || bus.busy !== 1'b0 || bus.step_ack !== 1'b0 ||
            bus.scan_out !== 1'b0 || bus.shift_done !== 1'b0 || bus.par_err !== 1'b0)
            $display("FAIL reset_init: ppi=%b busy=%b ack=%b so=%b done=%b perr=%b, want all zero",
                     bus.ppi, bus.busy, bus.step_ack, bus.scan_out, bus.shift_done, bus.par_err);
        else passes++;
        // Asynchronous reset in the middle of free-run with a step pending
        drive(0, 0, 0, 1, 5'b11011);
        repeat (3) tick();
        bus.step_req = 1'b1;
        #2 RST_N = 1'b0;
        #1;
        checks++;
        if (bus.ppi !== 5'b00000 || bus.busy !== 1'b0 || bus.step_ack !== 1'b0 || bus.scan_out !== 1'b0)
            $display("FAIL reset_async: ppi=%b busy=%b ack=%b so=%b, want zeros",
                     bus.ppi, bus.busy, bus.step_ack, bus.scan_out);
        else passes++;
        do_reset();
    endtask

    task automatic test_step();
        int acks = 0;
        drive(0, 0, 1, 0, 5'b10110);
        tick();
        checks++;
        if (bus.ppi !== 5'b10110 || bus.step_ack !== 1'b1)
            $display("FAIL step_capture: ppi=%b ack=%b, want 10110 and 1", bus.ppi, bus.step_ack);
        else passes++;
        acks = 1;
        bus.ppo = 5'b00001;
        repeat (3) begin
            tick();
            if (bus.step_ack === 1'b1) acks++;
        end
        checks++;
        if (acks != 1) $display("FAIL step_ack_count: got %0d pulses, want 1", acks);
        else passes++;
        checks++;
        if (bus.ppi !== 5'b10110) $display("FAIL step_held_req: ppi=%b, want 10110", bus.ppi);
        else passes++;
        bus.step_req = 1'b0;
        tick();
    endtask

    task automatic test_run();
        logic [W-1:0] seq [3] = '{5'd3, 5'd7, 5'd12};
        bus.run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.ppo = seq[i];
            tick();
            checks++;
            if (bus.ppi !== seq[i] || bus.busy !== 1'b1)
                $display("FAIL run_follow%0d: ppi=%0d busy=%b, want %0d and 1", i, bus.ppi, bus.busy, seq[i]);
            else passes++;
        end
        bus.run = 1'b0;
        bus.ppo = 5'd31;
        repeat (2) tick();
        checks++;
        if (bus.ppi !== 5'd12 || bus.busy !== 1'b0)
            $display("FAIL run_hold: ppi=%0d busy=%b, want 12 and 0", bus.ppi, bus.busy);
        else passes++;
    endtask

    task automatic test_scan();
        logic [W-1:0] old_st;
        logic [W-1:0] sin_bits;
        logic [W-1:0] unloaded;
        int done_cnt = 0;
        old_st   = bus.ppi;
        sin_bits = 5'b10110;  // applied MSB first: 1,0,1,1,0
        bus.scan_en = 1'b1;
        for (int i = 0; i < W; i++) begin
            bus.scan_in = sin_bits[W-1-i];
            unloaded[W-1-i] = bus.scan_out;
            tick();
            if (bus.shift_done === 1'b1) done_cnt++;
        end
        checks++;
        if (bus.ppi !== 5'b10110) $display("FAIL scan_load: ppi=%b, want 10110", bus.ppi);
        else passes++;
        checks++;
        if (unloaded !== old_st) $display("FAIL scan_unload: got %b, want %b", unloaded, old_st);
        else passes++;
        bus.scan_en = 1'b0;
        tick();
        checks++;
        if (done_cnt != 1 || bus.shift_done !== 1'b0)
            $display("FAIL scan_done: pulses=%0d after=%b, want 1 and 0", done_cnt, bus.shift_done);
        else passes++;
    endtask

    task automatic test_priority_abort();
        int acks = 0;
        int dones = 0;
        drive(1, 1, 1, 0, 5'b11111);
        tick();
        if (bus.step_ack === 1'b1) acks++;
        bus.scan_in = 1'b0;
        tick();
        if (bus.step_ack === 1'b1) acks++;
        checks++;
        if (bus.ppi !== 5'b11010 || acks != 0)
            $display("FAIL prio_shift: ppi=%b acks=%0d, want 11010 and 0", bus.ppi, acks);
        else passes++;
        bus.scan_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.shift_done === 1'b1) dones++;
            if (bus.step_ack === 1'b1) acks++;
        end
        checks++;
        if (dones != 0 || acks != 1 || bus.ppi !== 5'b11111)
            $display("FAIL abort_pending_step: dones=%0d acks=%0d ppi=%b, want 0 1 11111", dones, acks, bus.ppi);
        else passes++;
        bus.step_req = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int errs = 0;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            bit s, r, rn;
            s  = ($urandom % 4) == 0;
            rn = ($urandom % 5) < 2;
            r  = ($urandom % 6) == 0 ? ~bus.step_req : bus.step_req;
            drive(s, ($urandom % 2) == 1, r, rn, W'($urandom));
            if (bus.scan_out !== m_state[W-1]) begin
                errs++;
                checks++;
                $display("FAIL rnd_scan_out c%0d: got %b, want %b", c, bus.scan_out, m_state[W-1]);
            end
            tick();
            model_edge();
            checks++;
            if (bus.ppi !== m_state || bus.step_ack !== m_acking || bus.shift_done !== m_done ||
                bus.busy !== (m_shifting | m_running | m_acking) || bus.par_err !== 1'b0) begin
                errs++;
                $display("FAIL rnd c%0d: ppi=%b ack=%b done=%b busy=%b perr=%b, want %b %b %b %b 0",
                         c, bus.ppi, bus.step_ack, bus.shift_done, bus.busy, bus.par_err,
                         m_state, m_acking, m_done, m_shifting | m_running | m_acking);
            end else passes++;
            if (errs > 10) break;
        end
    endtask

`ifdef STATE_PARITY_EN
    task automatic test_parity();
        logic [W-1:0] upset;
        drive(0, 0, 0, 0, '0);
        tick();
        upset = bus.ppi ^ 5'b00100;
        force dut.state_q = upset;
        tick();
        release dut.state_q;
        tick();
        checks++;
        if (bus.par_err !== 1'b1) $display("FAIL parity_detect: par_err=%b, want 1", bus.par_err);
        else passes++;
        repeat (3) tick();
        checks++;
        if (bus.par_err !== 1'b1) $display("FAIL parity_sticky: par_err=%b, want 1", bus.par_err);
        else passes++;
    endtask
`endif

    initial begin
        test_reset();
        test_step();
        test_run();
        test_scan();
        test_priority_abort();
        test_random();
`ifdef STATE_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
